// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: transaction owner, tag FIFO entry
// and a constructor for freshly accepted entries.
package mem_port_arbiter_pkg;

    typedef enum logic {
        owner_if = 1'b0,
        owner_ls = 1'b1
    } mem_owner_t;

    typedef struct packed {
        mem_owner_t owner;
        logic       kill;
    } arb_entry_t;

    localparam arb_entry_t arb_entry_rst = '{owner: owner_if, kill: 1'b0};

    function automatic arb_entry_t make_entry(input mem_owner_t owner);
        arb_entry_t e;
        e.owner = owner;
        e.kill  = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// slave = arbiter view, master = view of the surrounding pipeline and memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic        ls_gnt;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_gnt;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rsp_valid, if_rsp_data,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
        output ls_gnt, ls_rsp_valid, ls_rsp_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_gnt, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rsp_valid, if_rsp_data,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
        input  ls_gnt, ls_rsp_valid, ls_rsp_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_gnt, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order tag FIFO of outstanding memory transactions; kill_if_i marks every
// fetch entry (including one pushed the same cycle) so its response is dropped.
module arb_tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  arb_entry_t push_entry_i,
    input  logic       pop_i,
    input  logic       kill_if_i,
    output arb_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    arb_entry_t       slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    arb_entry_t       in_entry_s;

    // Next-state pointers/count and the entry actually written on push.
    always_comb begin
        wr_ptr_d = push_i ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_i  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        in_entry_s       = push_entry_i;
        in_entry_s.kill  = push_entry_i.kill
                         | (kill_if_i & (push_entry_i.owner == owner_if));
    end

    assign head_o  = slot_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == (PTR_W + 1)'(0));

    // Storage, pointers and occupancy; kill marking applies to every slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= arb_entry_rst;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_if_i && (slot_q[i].owner == owner_if)) begin
                    slot_q[i].kill <= 1'b1;
                end
            end
            if (push_i) begin
                slot_q[wr_ptr_q] <= in_entry_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: zero-latency arbitration
// with starvation relief, in-order response routing and flush cancellation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_MAX      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    mem_port_arbiter_if.slave        bus,
    output logic                     busy,
    output logic                     err
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic             elig_if_s, elig_ls_s, if_wins_s, accept_s, pop_s;
    logic             fifo_full_s, fifo_empty_s;
    arb_entry_t       head_s, push_entry_s;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;

    // Arbitration, grants and the winner's fields onto the memory port.
    always_comb begin
        elig_if_s    = rst & bus.if_req & ~flush;
        elig_ls_s    = rst & bus.ls_req;
        if_wins_s    = elig_if_s & (~elig_ls_s | (starve_cnt_q == STARVE_LIM));
        bus.mem_req  = (elig_if_s | elig_ls_s) & ~fifo_full_s;
        accept_s     = bus.mem_req & bus.mem_gnt;
        bus.if_gnt   = accept_s & if_wins_s;
        bus.ls_gnt   = accept_s & ~if_wins_s;
        push_entry_s = make_entry(if_wins_s ? owner_if : owner_ls);
        if (!bus.mem_req) begin
            bus.mem_we    = 1'b0;
            bus.mem_addr  = 32'h0000_0000;
            bus.mem_wdata = 32'h0000_0000;
            bus.mem_mask  = 4'h0;
        end else if (if_wins_s) begin
            bus.mem_we    = 1'b0;
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = 32'h0000_0000;
            bus.mem_mask  = 4'hF;
        end else begin
            bus.mem_we    = bus.ls_we;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
            bus.mem_mask  = bus.ls_mask;
        end
    end

    // Response routing: the FIFO head names the owner; killed fetches vanish.
    always_comb begin
        pop_s            = rst & bus.mem_rsp_valid & ~fifo_empty_s;
        bus.ls_rsp_valid = pop_s & (head_s.owner == owner_ls);
        bus.if_rsp_valid = pop_s & (head_s.owner == owner_if) & ~head_s.kill;
        bus.ls_rsp_data  = bus.ls_rsp_valid ? bus.mem_rsp_data : 32'h0000_0000;
        bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rsp_data : 32'h0000_0000;
        busy             = rst & ~fifo_empty_s;
    end

    // Starvation counter next state and sticky protocol error.
    always_comb begin
        if (bus.if_gnt || !bus.if_req) begin
            starve_cnt_d = '0;
        end else if (elig_if_s && elig_ls_s && bus.ls_gnt) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                        : (starve_cnt_q + CNT_W'(1));
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        err_d = err_q | (bus.mem_rsp_valid & fifo_empty_s);
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    assign err = err_q;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (accept_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .kill_if_i    (flush),
        .head_o       (head_s),
        .full_o       (fifo_full_s),
        .empty_o      (fifo_empty_s)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for contention/routing,
// then hand-written sequences for full, ordering, flush and protocol error.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    logic flush;
    logic busy;
    logic err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_OUTSTANDING (4),
        .STARVE_MAX      (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // in  = {if_req, ls_req, flush, mem_gnt, mem_rsp_valid}
    // exp = {if_gnt, ls_gnt, mem_req, if_rsp_valid, ls_rsp_valid, busy, err}
    typedef struct {
        logic [4:0]  in;
        logic [6:0]  exp;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_in(input logic ifr, input logic lsr, input logic fl,
                          input logic gnt, input logic rv, input logic [31:0] rd);
        bus.if_req        = ifr;
        bus.ls_req        = lsr;
        flush             = fl;
        bus.mem_gnt       = gnt;
        bus.mem_rsp_valid = rv;
        bus.mem_rsp_data  = rd;
    endtask

    task automatic chk_flags(input string nm, input logic [6:0] exp);
        logic [6:0] act;
        act = {bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.if_rsp_valid,
               bus.ls_rsp_valid, busy, err};
        chk(nm, {25'd0, act}, {25'd0, exp});
    endtask

    initial begin
        logic [31:0] rd;
        rst           = 1'b0;
        bus.if_addr   = 32'h0000_0100;
        bus.ls_addr   = 32'h0000_0200;
        bus.ls_we     = 1'b0;
        bus.ls_wdata  = 32'h0000_0000;
        bus.ls_mask   = 4'hF;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        tbl[0]  = '{5'b11010, 7'b0110000, 32'h0000_0200};
        tbl[1]  = '{5'b11011, 7'b0110110, 32'h0000_0200};
        tbl[2]  = '{5'b11011, 7'b0110110, 32'h0000_0200};
        tbl[3]  = '{5'b11011, 7'b1010110, 32'h0000_0100};
        tbl[4]  = '{5'b11011, 7'b0111010, 32'h0000_0200};
        tbl[5]  = '{5'b11011, 7'b0110110, 32'h0000_0200};
        tbl[6]  = '{5'b11011, 7'b0110110, 32'h0000_0200};
        tbl[7]  = '{5'b11011, 7'b1010110, 32'h0000_0100};
        tbl[8]  = '{5'b00011, 7'b0001010, 32'h0000_0000};
        tbl[9]  = '{5'b00010, 7'b0000000, 32'h0000_0000};
        tbl[10] = '{5'b11110, 7'b0110000, 32'h0000_0200};
        tbl[11] = '{5'b00011, 7'b0000110, 32'h0000_0000};
        tbl[12] = '{5'b00010, 7'b0000000, 32'h0000_0000};

        // Reset held with both requests high.
        repeat (2) step();
        settle();
        chk_flags("reset_flags", 7'b0000000);

        // Table: release reset, contention with starvation relief, flush masking.
        for (int i = 0; i < 13; i++) begin
            step();
            rst = 1'b1;
            rd  = 32'hA000_0000 | i;
            set_in(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], rd);
            settle();
            chk_flags($sformatf("vec%0d_flags", i), tbl[i].exp);
            chk($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].addr);
            chk($sformatf("vec%0d_if_data", i), bus.if_rsp_data, tbl[i].exp[3] ? rd : 32'h0);
            chk($sformatf("vec%0d_ls_data", i), bus.ls_rsp_data, tbl[i].exp[2] ? rd : 32'h0);
        end

        // Full: four loads accepted, fifth cycle blocked.
        for (int i = 0; i < 4; i++) begin
            step();
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            settle();
            chk($sformatf("full_ls_gnt%0d", i), {31'd0, bus.ls_gnt}, 32'd1);
        end
        step();
        settle();
        chk_flags("full_block", 7'b0000010);
        step();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        settle();
        chk_flags("full_pop", 7'b0000110);
        chk("full_pop_data", bus.ls_rsp_data, 32'hDEAD_BEEF);
        step();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.ls_we    = 1'b1;
        bus.ls_wdata = 32'h1234_5678;
        bus.ls_mask  = 4'h3;
        settle();
        chk_flags("full_resume", 7'b0110010);
        chk("store_fields", {bus.mem_wdata[27:0], bus.mem_mask, bus.mem_we, 3'd0},
            {28'h234_5678, 4'h3, 1'b1, 3'd0});
        bus.ls_we   = 1'b0;
        bus.ls_mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0050 + i);
            settle();
            chk($sformatf("drain_ls_rsp%0d", i), {31'd0, bus.ls_rsp_valid}, 32'd1);
        end
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("drain_busy", {31'd0, busy}, 32'd0);

        // Ordering: IF@100, LS@200, IF@104, then responses A, B, C.
        step();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("ord_if0_gnt", {31'd0, bus.if_gnt}, 32'd1);
        chk("ord_if0_fields", {bus.mem_addr[27:0], bus.mem_mask}, {28'h000_0100, 4'hF});
        step();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("ord_ls_gnt", {31'd0, bus.ls_gnt}, 32'd1);
        step();
        bus.if_addr = 32'h0000_0104;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("ord_if1_addr", bus.mem_addr, 32'h0000_0104);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000A);
        settle();
        chk_flags("ord_rsp_a", 7'b0001010);
        chk("ord_rsp_a_data", bus.if_rsp_data, 32'h0000_000A);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000B);
        settle();
        chk_flags("ord_rsp_b", 7'b0000110);
        chk("ord_rsp_b_data", bus.ls_rsp_data, 32'h0000_000B);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
        settle();
        chk_flags("ord_rsp_c", 7'b0001010);
        chk("ord_rsp_c_data", bus.if_rsp_data, 32'h0000_000C);

        // Flush: IF, LS, IF accepted, flush with if_req high, then three responses.
        step();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("fl_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
        step();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        chk_flags("fl_masked", 7'b0000010);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0011);
        settle();
        chk_flags("fl_rsp1", 7'b0000010);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0022);
        settle();
        chk_flags("fl_rsp2", 7'b0000110);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0033);
        settle();
        chk_flags("fl_rsp3", 7'b0000010);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("fl_busy_drop", {31'd0, busy}, 32'd0);

        // Protocol error: response with nothing outstanding.
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0099);
        settle();
        chk_flags("err_rsp_dropped", 7'b0000000);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("err_set", {31'd0, err}, 32'd1);
        repeat (3) step();
        settle();
        chk("err_held", {31'd0, err}, 32'd1);
        step();
        rst = 1'b0;
        settle();
        chk("err_before_rst_edge", {31'd0, err}, 32'd1);
        step();
        settle();
        chk("err_cleared", {31'd0, err}, 32'd0);
        step();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk_flags("post_rst_ls_first", 7'b0110000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
